// File: rtl/rr_select_gen.sv
// Round-robin one-hot select generator: grants one requester at a time and rotates priority on grant end.
// Optional grant timeout compiled in with `define RR_SEL_TIMEOUT_EN.
module rr_select_gen #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16,
    localparam int IDXW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic             release_i,
    output logic [WIDTH-1:0] select,
    output logic             sel_valid,
    output logic [IDXW-1:0]  sel_idx,
    output logic             timeout,
    output logic             dbg_grant,
    output logic [IDXW-1:0]  dbg_ptr
);

    // Handshake: req is level-sensitive and owns the grant while high; release_i is a
    // one-cycle pulse ending the grant. Either ending returns to IDLE for at least one cycle.
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] select_q, select_d;
    logic [IDXW-1:0]  sel_idx_q, sel_idx_d;
    logic             sel_valid_q, sel_valid_d;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_found;
    logic             end_grant;
    logic [IDXW-1:0]  next_ptr;

    if (TIMEOUT < 1) begin : g_timeout_range_bad
        $error("TIMEOUT must be at least 1");
    end

`ifdef RR_SEL_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            forced;
`endif

    // First requester at or after ptr, wrapping modulo WIDTH.
    always_comb begin
        int cand;
        logic [IDXW-1:0] cand_idx;
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand     = (int'(ptr_q) + i) % WIDTH;
            cand_idx = IDXW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign end_grant = release_i || !req[sel_idx_q];
    assign next_ptr  = (sel_idx_q == IDXW'(WIDTH - 1)) ? '0 : sel_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        select_d    = select_q;
        sel_idx_d   = sel_idx_q;
        sel_valid_d = sel_valid_q;
`ifdef RR_SEL_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        forced    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    select_d    = WIDTH'(1) << pick_idx;
                    sel_idx_d   = pick_idx;
                    sel_valid_d = 1'b1;
`ifdef RR_SEL_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_SEL_TIMEOUT_EN
                forced = !end_grant && (cnt_q == CNTW'(TIMEOUT - 1));
                if (end_grant || forced) begin
                    timeout_d = forced;
`else
                if (end_grant) begin
`endif
                    state_d     = IDLE;
                    select_d    = '0;
                    sel_idx_d   = '0;
                    sel_valid_d = 1'b0;
                    ptr_d       = next_ptr;
                end
`ifdef RR_SEL_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            select_q    <= '0;
            sel_idx_q   <= '0;
            sel_valid_q <= 1'b0;
`ifdef RR_SEL_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            select_q    <= select_d;
            sel_idx_q   <= sel_idx_d;
            sel_valid_q <= sel_valid_d;
`ifdef RR_SEL_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign select    = select_q;
    assign sel_valid = sel_valid_q;
    assign sel_idx   = sel_idx_q;
    assign dbg_grant = (state_q == GRANT);
    assign dbg_ptr   = ptr_q;
`ifdef RR_SEL_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_select_gen.sv
// Bench for rr_select_gen (WIDTH=4, TIMEOUT=4): vector table, hand sequences, randomized run vs. reference model.
module tb_rr_select_gen;

    localparam int W          = 4;
    localparam int TB_TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] req;
    logic         rel;
    logic [W-1:0] select;
    logic         sel_valid;
    logic [1:0]   sel_idx;
    logic         timeout;
    logic         dbg_grant;
    logic [1:0]   dbg_ptr;

    int n_total = 0;
    int n_pass  = 0;

    rr_select_gen #(.WIDTH(W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (rel),
        .select    (select),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .timeout   (timeout),
        .dbg_grant (dbg_grant),
        .dbg_ptr   (dbg_ptr)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 when idle), priority pointer, visible-cycle count.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [W-1:0] r, input logic rl);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < W; i++) begin
                int j;
                j = (m_ptr + i) % W;
                if (m_owner < 0 && r[j]) begin
                    m_owner = j;
                    m_hold  = 0;
                end
            end
        end else if (rl || !r[m_owner]) begin
            m_ptr   = (m_owner + 1) % W;
            m_owner = -1;
        end else begin
            m_hold++;
`ifdef RR_SEL_TIMEOUT_EN
            if (m_hold >= TB_TIMEOUT) begin
                m_ptr   = (m_owner + 1) % W;
                m_owner = -1;
                m_to    = 1'b1;
            end
`endif
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_vs_model(input string tag);
        logic [W-1:0] e_sel;
        e_sel = (m_owner >= 0) ? W'(1 << m_owner) : '0;
        chk({tag, ".sel"},   32'(select),    32'(e_sel));
        chk({tag, ".valid"}, 32'(sel_valid), 32'(m_owner >= 0));
        chk({tag, ".idx"},   32'(sel_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk({tag, ".to"},    32'(timeout),   32'(m_to));
        chk({tag, ".ptr"},   32'(dbg_ptr),   32'(m_ptr));
        chk({tag, ".onehot"}, 32'($countones(select) <= 1), 32'd1);
    endtask

    // Called at a negedge: apply inputs, let one rising edge happen, check at the next negedge.
    task automatic step(input logic [W-1:0] r, input logic rl, input string tag);
        req = r;
        rel = rl;
        @(posedge clk);
        model_step(r, rl);
        @(negedge clk);
        check_vs_model(tag);
    endtask

    typedef struct {
        logic [W-1:0] req;
        logic         rel;
        logic [W-1:0] sel;
        logic [1:0]   ptr;
    } vec_t;

    vec_t tbl[23];

    logic [W-1:0] to_sel[6];
    logic         to_pulse[6];
    logic [W-1:0] cur_req;
    logic         cur_rel;

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd1};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd2};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd3};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd0};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0};
        tbl[9]  = '{4'b0010, 1'b0, 4'b0000, 2'd1};
        tbl[10] = '{4'b0010, 1'b0, 4'b0010, 2'd1};
        tbl[11] = '{4'b0010, 1'b1, 4'b0000, 2'd2};
        tbl[12] = '{4'b0011, 1'b0, 4'b0001, 2'd2};
        tbl[13] = '{4'b0011, 1'b0, 4'b0001, 2'd2};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 2'd1};
        tbl[15] = '{4'b0000, 1'b1, 4'b0000, 2'd1};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 2'd1};
        tbl[17] = '{4'b0010, 1'b0, 4'b0010, 2'd1};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 2'd2};
        tbl[19] = '{4'b1100, 1'b0, 4'b0100, 2'd2};
        tbl[20] = '{4'b0111, 1'b0, 4'b0100, 2'd2};
        tbl[21] = '{4'b1111, 1'b0, 4'b0100, 2'd2};
        tbl[22] = '{4'b0000, 1'b1, 4'b0000, 2'd3};

`ifdef RR_SEL_TIMEOUT_EN
        to_sel   = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
        to_pulse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        to_sel   = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        to_pulse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

        // Clock/reset
        rst_n = 1'b0;
        req   = '0;
        rel   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.sel",   32'(select),    32'd0);
        chk("reset.valid", 32'(sel_valid), 32'd0);
        chk("reset.idx",   32'(sel_idx),   32'd0);
        chk("reset.to",    32'(timeout),   32'd0);
        chk("reset.ptr",   32'(dbg_ptr),   32'd0);
        rst_n = 1'b1;

        // Vector table: rotation, wrap, drop, idle release, hold under changing req.
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].req, tbl[i].rel, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.vec_sel", i), 32'(select),  32'(tbl[i].sel));
            chk($sformatf("tbl%0d.vec_ptr", i), 32'(dbg_ptr), 32'(tbl[i].ptr));
        end

        // Asynchronous reset in the middle of a grant to index 2.
        step(4'b0100, 1'b0, "pre_rst");
        chk("pre_rst.sel", 32'(select), 32'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.sel",   32'(select),    32'd0);
        chk("async_rst.valid", 32'(sel_valid), 32'd0);
        chk("async_rst.idx",   32'(sel_idx),   32'd0);
        chk("async_rst.ptr",   32'(dbg_ptr),   32'd0);
        chk("async_rst.state", 32'(dbg_grant), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(4'b1111, 1'b0, "post_rst");
        chk("post_rst.sel", 32'(select), 32'b0001);
        step(4'b0000, 1'b1, "post_rst_rel");

        // Single requester held with no release: timeout behaviour or indefinite hold.
        for (int i = 0; i < 6; i++) begin
            step(4'b1000, 1'b0, $sformatf("hold%0d", i));
            chk($sformatf("hold%0d.vec_sel", i), 32'(select),  32'(to_sel[i]));
            chk($sformatf("hold%0d.vec_to", i),  32'(timeout), 32'(to_pulse[i]));
        end
        step(4'b0000, 1'b1, "hold_end");

        // Randomized run against the reference model, with one mid-run reset.
        cur_req = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur_req = W'($urandom_range(0, 15));
            cur_rel = ($urandom_range(0, 5) == 0);
            step(cur_req, cur_rel, $sformatf("rnd%0d", i));
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst.sel", 32'(select),  32'd0);
                chk("rnd_rst.ptr", 32'(dbg_ptr), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
